// File: rtl/exec_cond_stage_pkg.sv
// Shared processor definitions for the execute-stage condition logic:
// ARM-style condition codes, NZCV bit positions and the E->M register payload.
package exec_cond_stage_pkg;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    typedef enum logic [3:0] {
        EQ  = 4'b0000,
        NE  = 4'b0001,
        CS  = 4'b0010,
        CC  = 4'b0011,
        MI  = 4'b0100,
        PL  = 4'b0101,
        VS  = 4'b0110,
        VC  = 4'b0111,
        HI  = 4'b1000,
        LS  = 4'b1001,
        GE  = 4'b1010,
        LT  = 4'b1011,
        GT  = 4'b1100,
        LE  = 4'b1101,
        AL  = 4'b1110,
        UNC = 4'b1111
    } cond_e;

    typedef struct packed {
        logic        pcsrc;
        logic        reg_write;
        logic        mem_to_reg;
        logic        mem_write;
        logic [3:0]  rd;
        logic [31:0] alu_result;
        logic [31:0] write_data;
    } m_reg_t;

endpackage

// File: rtl/exec_cond_stage_cond_check.sv
// Purely combinational condition-code evaluator: decides whether the
// instruction in E executes, given the registered NZCV flags.
module cond_check
    import exec_cond_stage_pkg::*;
(
    input  logic [3:0] CondE,
    input  logic [3:0] FlagsQ,
    output logic       CondExE
);

    logic n, z, c, v;

    assign n = FlagsQ[FLAG_N];
    assign z = FlagsQ[FLAG_Z];
    assign c = FlagsQ[FLAG_C];
    assign v = FlagsQ[FLAG_V];

    // NOTE: assign a default before the case so every path drives the output and no latch is inferred.
    always_comb begin
        CondExE = 1'b1;
        case (cond_e'(CondE))
            EQ:  CondExE = z;
            NE:  CondExE = ~z;
            CS:  CondExE = c;
            CC:  CondExE = ~c;
            MI:  CondExE = n;
            PL:  CondExE = ~n;
            VS:  CondExE = v;
            VC:  CondExE = ~v;
            HI:  CondExE = c & ~z;
            LS:  CondExE = ~c | z;
            GE:  CondExE = (n == v);
            LT:  CondExE = (n != v);
            GT:  CondExE = ~z & (n == v);
            LE:  CondExE = z | (n != v);
            AL:  CondExE = 1'b1;
            UNC: CondExE = 1'b1;
            default: CondExE = 1'b1;
        endcase
    end

endmodule

// File: rtl/exec_cond_stage.sv
// Execute-stage conditional execution: NZCV flag register, condition gating of
// side-effecting controls, and the E->M pipeline register with stall/flush.
module exec_cond_stage
    import exec_cond_stage_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        PCSrcE,
    input  logic        RegWriteE,
    input  logic        MemtoRegE,
    input  logic        MemWriteE,
    input  logic [1:0]  FlagWriteE,
    input  logic [3:0]  CondE,
    input  logic [3:0]  RdE,
    input  logic [3:0]  ALUFlags,
    input  logic [31:0] ALUResultE,
    input  logic [31:0] WriteDataE,
    input  logic        StallM,
    input  logic        FlushM,
    output logic        PCSrcM,
    output logic        RegWriteM,
    output logic        MemtoRegM,
    output logic        MemWriteM,
    output logic [3:0]  RdM,
    output logic [31:0] ALUResultM,
    output logic [31:0] WriteDataM,
    output logic        CondExE,
    output logic        BranchTakenE,
    output logic [3:0]  FlagsQ
);

    logic [3:0] flags_d, flags_q;
    m_reg_t     m_d, m_q;
    logic       flag_en;

    cond_check u_cond_check (
        .CondE   (CondE),
        .FlagsQ  (flags_q),
        .CondExE (CondExE)
    );

    assign BranchTakenE = PCSrcE & CondExE;

    // A squashed, stalled or flushed instruction must not disturb the flags.
    assign flag_en = CondExE & ~StallM & ~FlushM;

    always_comb begin
        flags_d = flags_q;
        if (flag_en) begin
            if (FlagWriteE[1]) begin
                flags_d[FLAG_N] = ALUFlags[FLAG_N];
                flags_d[FLAG_Z] = ALUFlags[FLAG_Z];
            end
            if (FlagWriteE[0]) begin
                flags_d[FLAG_C] = ALUFlags[FLAG_C];
                flags_d[FLAG_V] = ALUFlags[FLAG_V];
            end
        end
    end

    // Flush wins over stall; a failed condition turns the instruction into a no-op.
    always_comb begin
        m_d = m_q;
        if (FlushM) begin
            m_d = '0;
        end else if (!StallM) begin
            m_d.pcsrc      = PCSrcE & CondExE;
            m_d.reg_write  = RegWriteE & CondExE;
            m_d.mem_to_reg = MemtoRegE;
            m_d.mem_write  = MemWriteE & CondExE;
            m_d.rd         = RdE;
            m_d.alu_result = ALUResultE;
            m_d.write_data = WriteDataE;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            flags_q <= '0;
            m_q     <= '0;
        end else begin
            flags_q <= flags_d;
            m_q     <= m_d;
        end
    end

    assign FlagsQ     = flags_q;
    assign PCSrcM     = m_q.pcsrc;
    assign RegWriteM  = m_q.reg_write;
    assign MemtoRegM  = m_q.mem_to_reg;
    assign MemWriteM  = m_q.mem_write;
    assign RdM        = m_q.rd;
    assign ALUResultM = m_q.alu_result;
    assign WriteDataM = m_q.write_data;

endmodule

// File: tb/tb_exec_cond_stage.sv
// Self-checking bench for exec_cond_stage: behavioural model compared every
// negative edge, directed scenarios with literal expectations, then random traffic.
module tb_exec_cond_stage;

    logic        clk;
    logic        reset;
    logic        PCSrcE, RegWriteE, MemtoRegE, MemWriteE;
    logic [1:0]  FlagWriteE;
    logic [3:0]  CondE, RdE, ALUFlags;
    logic [31:0] ALUResultE, WriteDataE;
    logic        StallM, FlushM;
    logic        PCSrcM, RegWriteM, MemtoRegM, MemWriteM;
    logic [3:0]  RdM;
    logic [31:0] ALUResultM, WriteDataM;
    logic        CondExE, BranchTakenE;
    logic [3:0]  FlagsQ;

    int tests_run = 0;
    int tests_failed = 0;

    exec_cond_stage dut (
        .clk          (clk),
        .reset        (reset),
        .PCSrcE       (PCSrcE),
        .RegWriteE    (RegWriteE),
        .MemtoRegE    (MemtoRegE),
        .MemWriteE    (MemWriteE),
        .FlagWriteE   (FlagWriteE),
        .CondE        (CondE),
        .RdE          (RdE),
        .ALUFlags     (ALUFlags),
        .ALUResultE   (ALUResultE),
        .WriteDataE   (WriteDataE),
        .StallM       (StallM),
        .FlushM       (FlushM),
        .PCSrcM       (PCSrcM),
        .RegWriteM    (RegWriteM),
        .MemtoRegM    (MemtoRegM),
        .MemWriteM    (MemWriteM),
        .RdM          (RdM),
        .ALUResultM   (ALUResultM),
        .WriteDataM   (WriteDataM),
        .CondExE      (CondExE),
        .BranchTakenE (BranchTakenE),
        .FlagsQ       (FlagsQ)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ARM rule: even codes test a base predicate, odd codes test its inverse; 111x always.
    function automatic bit cond_ok(input logic [3:0] cc, input logic [3:0] f);
        bit n, z, c, v, base;
        n = f[3]; z = f[2]; c = f[1]; v = f[0];
        case (cc[3:1])
            3'd0: base = z;
            3'd1: base = c;
            3'd2: base = n;
            3'd3: base = v;
            3'd4: base = c && !z;
            3'd5: base = (n == v);
            3'd6: base = !z && (n == v);
            default: base = 1'b1;
        endcase
        if (cc[0] && cc[3:1] != 3'd7) base = !base;
        return base;
    endfunction

    // Behavioural model state
    logic [3:0]  mdl_flags = '0;
    logic        mdl_pcsrc = 0, mdl_regwr = 0, mdl_memtoreg = 0, mdl_memwr = 0;
    logic [3:0]  mdl_rd = '0;
    logic [31:0] mdl_alu = '0, mdl_wd = '0;

    always @(posedge clk or posedge reset) begin
        bit pass;
        if (reset) begin
            mdl_flags = '0;
            mdl_pcsrc = 0; mdl_regwr = 0; mdl_memtoreg = 0; mdl_memwr = 0;
            mdl_rd = '0; mdl_alu = '0; mdl_wd = '0;
        end else begin
            pass = cond_ok(CondE, mdl_flags);
            if (pass && !StallM && !FlushM) begin
                if (FlagWriteE[1]) mdl_flags[3:2] = ALUFlags[3:2];
                if (FlagWriteE[0]) mdl_flags[1:0] = ALUFlags[1:0];
            end
            if (FlushM) begin
                mdl_pcsrc = 0; mdl_regwr = 0; mdl_memtoreg = 0; mdl_memwr = 0;
                mdl_rd = '0; mdl_alu = '0; mdl_wd = '0;
            end else if (!StallM) begin
                mdl_pcsrc    = PCSrcE && pass;
                mdl_regwr    = RegWriteE && pass;
                mdl_memtoreg = MemtoRegE;
                mdl_memwr    = MemWriteE && pass;
                mdl_rd       = RdE;
                mdl_alu      = ALUResultE;
                mdl_wd       = WriteDataE;
            end
        end
    end

    always @(negedge clk) begin
        bit exp_cond;
        exp_cond = cond_ok(CondE, mdl_flags);
        check("cmp_CondExE", 32'(CondExE), 32'(exp_cond));
        check("cmp_BranchTakenE", 32'(BranchTakenE), 32'(PCSrcE && exp_cond));
        check("cmp_FlagsQ", 32'(FlagsQ), 32'(mdl_flags));
        check("cmp_PCSrcM", 32'(PCSrcM), 32'(mdl_pcsrc));
        check("cmp_RegWriteM", 32'(RegWriteM), 32'(mdl_regwr));
        check("cmp_MemtoRegM", 32'(MemtoRegM), 32'(mdl_memtoreg));
        check("cmp_MemWriteM", 32'(MemWriteM), 32'(mdl_memwr));
        check("cmp_RdM", 32'(RdM), 32'(mdl_rd));
        check("cmp_ALUResultM", ALUResultM, mdl_alu);
        check("cmp_WriteDataM", WriteDataM, mdl_wd);
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        PCSrcE = 0; RegWriteE = 0; MemtoRegE = 0; MemWriteE = 0;
        FlagWriteE = 2'b00; CondE = 4'b1110; RdE = '0; ALUFlags = '0;
        ALUResultE = '0; WriteDataE = '0; StallM = 0; FlushM = 0;
    endtask

    logic [15:0] reset_pass_mask;

    initial begin
        reset = 1'b1;
        idle_inputs();
        reset_pass_mask = 16'hD6AA;
        #12;
        check("reset_FlagsQ", 32'(FlagsQ), 32'h0);
        check("reset_RegWriteM", 32'(RegWriteM), 32'h0);
        check("reset_ALUResultM", ALUResultM, 32'h0);
        reset = 1'b0;
        tick();

        // All condition codes against cleared flags
        for (int c = 0; c < 16; c++) begin
            CondE = 4'(c);
            #1;
            check($sformatf("zero_flags_cond_%0d", c), 32'(CondExE), 32'(reset_pass_mask[c]));
            tick();
        end

        // EQ with Z=0 squashes the write; AL lets it through
        CondE = 4'b0000; RegWriteE = 1;
        #1 check("eq_squash_CondExE", 32'(CondExE), 32'h0);
        tick();
        check("eq_squash_RegWriteM", 32'(RegWriteM), 32'h0);
        CondE = 4'b1110;
        tick();
        check("al_RegWriteM", 32'(RegWriteM), 32'h1);

        // Full flag write, then a taken EQ branch
        RegWriteE = 0; FlagWriteE = 2'b11; ALUFlags = 4'b0100;
        tick();
        check("flags_write_11", 32'(FlagsQ), 32'h4);
        FlagWriteE = 2'b00; CondE = 4'b0000; PCSrcE = 1;
        #1 check("eq_BranchTakenE", 32'(BranchTakenE), 32'h1);
        tick();
        check("eq_PCSrcM", 32'(PCSrcM), 32'h1);

        // Partial write: only C,V
        PCSrcE = 0; CondE = 4'b1110; FlagWriteE = 2'b01; ALUFlags = 4'b1011;
        tick();
        check("flags_write_01", 32'(FlagsQ), 32'h7);

        // Stall holds M register and flags
        FlagWriteE = 2'b00; ALUResultE = 32'd3;
        tick();
        check("pre_stall_ALUResultM", ALUResultM, 32'd3);
        StallM = 1; FlagWriteE = 2'b11; ALUFlags = 4'b1111; ALUResultE = 32'd5;
        tick();
        ALUResultE = 32'd9;
        tick();
        check("stall_ALUResultM", ALUResultM, 32'd3);
        check("stall_FlagsQ", 32'(FlagsQ), 32'h7);
        StallM = 0; FlagWriteE = 2'b00;
        tick();
        check("post_stall_ALUResultM", ALUResultM, 32'd9);

        // Flush beats stall
        StallM = 1; FlushM = 1; MemWriteE = 1; RdE = 4'd5; FlagWriteE = 2'b11; ALUFlags = 4'b0000;
        tick();
        check("flush_MemWriteM", 32'(MemWriteM), 32'h0);
        check("flush_RdM", 32'(RdM), 32'h0);
        check("flush_FlagsQ", 32'(FlagsQ), 32'h7);

        // Asynchronous reset between edges, with a stall pending
        StallM = 0; FlushM = 0; MemWriteE = 0; RegWriteE = 1; FlagWriteE = 2'b11; ALUFlags = 4'hF;
        tick();
        check("pre_reset_RegWriteM", 32'(RegWriteM), 32'h1);
        check("pre_reset_FlagsQ", 32'(FlagsQ), 32'hF);
        StallM = 1;
        #1 reset = 1'b1;
        #1;
        check("async_reset_RegWriteM", 32'(RegWriteM), 32'h0);
        check("async_reset_FlagsQ", 32'(FlagsQ), 32'h0);
        reset = 1'b0;
        StallM = 0; FlagWriteE = 2'b00; RdE = 4'd9;
        tick();
        check("resume_RdM", 32'(RdM), 32'd9);

        // Random traffic against the model
        for (int i = 0; i < 3000; i++) begin
            tick();
            PCSrcE     = 1'($urandom);
            RegWriteE  = 1'($urandom);
            MemtoRegE  = 1'($urandom);
            MemWriteE  = 1'($urandom);
            FlagWriteE = 2'($urandom);
            CondE      = 4'($urandom);
            RdE        = 4'($urandom);
            ALUFlags   = 4'($urandom);
            ALUResultE = $urandom;
            WriteDataE = $urandom;
            StallM     = ($urandom_range(0, 5) == 0);
            FlushM     = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 249) == 0) begin
                #1 reset = 1'b1;
                #1 reset = 1'b0;
            end
        end

        tick();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
